// File: rtl/temac_tx_arb_if.sv
// Client-side TX bus of the TEMAC arbiter: N_CH byte-stream sources in,
// one EMAC client TX port out. The arbiter takes the slave side.
interface temac_tx_arb_if #(
  parameter int N_CH = 4
);
  logic [8*N_CH-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH-1:0]   ch_last;
  logic [N_CH-1:0]   ch_ready;
  logic [7:0]        mac_tx_data;
  logic              mac_tx_dvld;
  logic              mac_tx_underrun;
  logic              mac_tx_ack;

  modport master (
    output ch_data, ch_valid, ch_last, mac_tx_ack,
    input  ch_ready, mac_tx_data, mac_tx_dvld, mac_tx_underrun
  );

  modport slave (
    input  ch_data, ch_valid, ch_last, mac_tx_ack,
    output ch_ready, mac_tx_data, mac_tx_dvld, mac_tx_underrun
  );
endinterface

// File: rtl/temac_tx_arb.sv
// Per-frame round-robin transmit arbiter for the Virtex-6 TEMAC client TX port.
// Pads short frames with zeros, aborts on source underrun or missing ack, and
// counts completed frames and both abort kinds.
module temac_tx_arb #(
  parameter int N_CH        = 4,
  parameter int MIN_LEN     = 60,
  parameter int PAD_EN      = 1,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk_125,
  input  logic              reset,
  temac_tx_arb_if.slave     tx,
  output logic [N_CH-1:0]   gnt,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       timeout_cnt
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (MIN_LEN > 0) ? $clog2(MIN_LEN + 1) : 1;
  localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_LEN);
  localparam logic [WW-1:0] TO_LIM  = WW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_CH = IW'(N_CH - 1);

  typedef enum logic [2:0] {IDLE, FIRST, DATA, PAD, FLUSH, GAP} st_t;

  st_t           st;
  logic [IW-1:0] ptr, gidx, win;
  logic          found;
  logic [7:0]    w_data, g_data;
  logic          w_last, g_valid, g_last;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  logic          last_seen;
  logic          adv, done;

  // Round-robin search: first valid channel after the pointer, wrapping.
  always_comb begin
    int p;
    p      = 0;
    found  = 1'b0;
    win    = ptr;
    w_data = '0;
    w_last = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      p = int'(ptr) + k;
      if (p >= N_CH) p = p - N_CH;
      if (!found && tx.ch_valid[p]) begin
        found  = 1'b1;
        win    = IW'(p);
        w_data = tx.ch_data[8*p +: 8];
        w_last = tx.ch_last[p];
      end
    end
  end

  // Mux of the granted channel's byte stream.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (IW'(i) == gidx) begin
        g_data  = tx.ch_data[8*i +: 8];
        g_valid = tx.ch_valid[i];
        g_last  = tx.ch_last[i];
      end
    end
  end

  // An advance cycle is one where the MAC consumes the byte on the bus.
  assign adv  = (st == FIRST && tx.mac_tx_ack) || st == DATA || st == PAD;
  assign done = last_seen && (PAD_EN == 0 || cnt >= MIN_C);

  // Source handshake: only the winner/owner ever sees ready; forced low in reset.
  always_comb begin
    tx.ch_ready = '0;
    if (!reset) begin
      case (st)
        IDLE:            if (found) tx.ch_ready[win] = 1'b1;
        FIRST, DATA, PAD: if (adv && !last_seen) tx.ch_ready[gidx] = 1'b1;
        FLUSH:           tx.ch_ready[gidx] = 1'b1;
        default:         ;
      endcase
    end
  end

  // Frame FSM with registered MAC outputs, grant and counters.
  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) begin
      st                 <= IDLE;
      ptr                <= LAST_CH;
      gidx               <= '0;
      gnt                <= '0;
      cnt                <= '0;
      wait_cnt           <= '0;
      last_seen          <= 1'b0;
      tx.mac_tx_data     <= '0;
      tx.mac_tx_dvld     <= 1'b0;
      tx.mac_tx_underrun <= 1'b0;
      frame_cnt          <= '0;
      underrun_cnt       <= '0;
      timeout_cnt        <= '0;
    end else begin
      tx.mac_tx_underrun <= 1'b0;
      if (adv) begin
        if (done) begin
          tx.mac_tx_dvld <= 1'b0;
          frame_cnt      <= frame_cnt + 32'd1;
          st             <= GAP;
        end else if (last_seen) begin
          // Source finished early: fill with zeros up to the minimum length.
          tx.mac_tx_data <= '0;
          if (cnt != MIN_C) cnt <= cnt + CW'(1);
          st             <= PAD;
        end else if (g_valid) begin
          tx.mac_tx_data <= g_data;
          if (cnt != MIN_C) cnt <= cnt + CW'(1);
          last_seen      <= g_last;
          st             <= DATA;
        end else begin
          tx.mac_tx_underrun <= 1'b1;
          tx.mac_tx_dvld     <= 1'b0;
          underrun_cnt       <= underrun_cnt + 16'd1;
          st                 <= FLUSH;
        end
      end else begin
        case (st)
          IDLE: if (found) begin
            tx.mac_tx_data <= w_data;
            tx.mac_tx_dvld <= 1'b1;
            gidx           <= win;
            gnt            <= '0;
            gnt[win]       <= 1'b1;
            cnt            <= CW'(1);
            last_seen      <= w_last;
            wait_cnt       <= '0;
            st             <= FIRST;
          end
          FIRST: begin
            if (ACK_TIMEOUT != 0 && wait_cnt == TO_LIM) begin
              tx.mac_tx_dvld <= 1'b0;
              timeout_cnt    <= timeout_cnt + 16'd1;
              st             <= last_seen ? GAP : FLUSH;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
          FLUSH: if (g_valid && g_last) st <= GAP;
          GAP: begin
            ptr <= gidx;
            gnt <= '0;
            st  <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_temac_tx_arb.sv
// Directed bench for temac_tx_arb: DUT A (4 ch, pad, 16-cycle ack timeout)
// covers padding, round-robin, underrun, timeout and async reset; DUT B
// (2 ch, no pad, no timeout) covers the disabled timeout and a 1-byte frame.
module tb_temac_tx_arb;
  logic clk_125 = 1'b0;
  logic reset;
  always #4 clk_125 = ~clk_125;

  temac_tx_arb_if #(.N_CH(4)) aif ();
  temac_tx_arb_if #(.N_CH(2)) bif ();

  logic [3:0]  a_gnt;
  logic [31:0] a_fc;
  logic [15:0] a_uc, a_tc;
  logic [1:0]  b_gnt;
  logic [31:0] b_fc;
  logic [15:0] b_uc, b_tc;

  temac_tx_arb #(.N_CH(4), .MIN_LEN(60), .PAD_EN(1), .ACK_TIMEOUT(16)) dut_a (
    .clk_125(clk_125), .reset(reset), .tx(aif), .gnt(a_gnt),
    .frame_cnt(a_fc), .underrun_cnt(a_uc), .timeout_cnt(a_tc));

  temac_tx_arb #(.N_CH(2), .MIN_LEN(60), .PAD_EN(0), .ACK_TIMEOUT(0)) dut_b (
    .clk_125(clk_125), .reset(reset), .tx(bif), .gnt(b_gnt),
    .frame_cnt(b_fc), .underrun_cnt(b_uc), .timeout_cnt(b_tc));

  int total = 0;
  int bad   = 0;

  logic [8:0] srcq [4][$];   // {last, data} per channel
  int popped [4], stall_at [4], stall_rem [4];

  logic [7:0] cap [$];       // bytes the MAC accepted (from ack onward)
  int len_log [$], run_log [$], gap_log [$];
  logic [3:0] gnt_log [$];
  logic prev_dv, seen_fall, ack_pend, acked, ack_en;
  int ack_wait, hi_run, low_run, cur_len, ur_n, ur_bad, ur_at, hi, nz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < 4; c++) begin
      srcq[c].delete();
      popped[c] = 0; stall_at[c] = -1; stall_rem[c] = 0;
    end
    cap.delete(); len_log.delete(); run_log.delete(); gap_log.delete(); gnt_log.delete();
    prev_dv = 0; seen_fall = 0; ack_pend = 0; acked = 0; ack_en = 1;
    ack_wait = 0; hi_run = 0; low_run = 0; cur_len = 0; ur_n = 0; ur_bad = 0; ur_at = -1;
  endtask

  task automatic push_frame(input int c, input int n, input logic [7:0] first, input logic [7:0] base);
    for (int k = 0; k < n; k++)
      srcq[c].push_back({(k == n - 1), (k == 0) ? first : 8'(base + k)});
  endtask

  task automatic drive_src();
    for (int c = 0; c < 4; c++) begin
      logic stl;
      stl = (popped[c] == stall_at[c] && stall_rem[c] > 0);
      if (stl) stall_rem[c]--;
      if (srcq[c].size() > 0 && !stl) begin
        aif.ch_valid[c]      = 1'b1;
        aif.ch_data[8*c +: 8] = srcq[c][0][7:0];
        aif.ch_last[c]       = srcq[c][0][8];
      end else begin
        aif.ch_valid[c]      = 1'b0;
        aif.ch_data[8*c +: 8] = 8'h00;
        aif.ch_last[c]       = 1'b0;
      end
    end
  endtask

  // One clock of DUT A: apply handshakes, refresh sources, monitor MAC side, drive ack.
  task automatic tick();
    logic [3:0] fire;
    logic dv, ack;
    #1 fire = aif.ch_valid & aif.ch_ready;
    @(posedge clk_125); #1;
    for (int c = 0; c < 4; c++)
      if (fire[c]) begin srcq[c].delete(0); popped[c]++; end
    drive_src();
    dv = aif.mac_tx_dvld;
    if (dv && !prev_dv) begin
      gnt_log.push_back(a_gnt);
      if (seen_fall) gap_log.push_back(low_run);
      ack_pend = 1; ack_wait = 3; acked = 0; hi_run = 0; cur_len = 0;
    end
    if (!dv && prev_dv) begin
      run_log.push_back(hi_run); len_log.push_back(cur_len);
      seen_fall = 1; low_run = 0;
    end
    if (aif.mac_tx_underrun) begin
      ur_n++; ur_at = cur_len;
      if (dv) ur_bad++;
    end
    if (dv) hi_run++; else low_run++;
    ack = 0;
    if (dv && ack_pend && ack_en) begin
      if (ack_wait == 0) begin ack = 1; ack_pend = 0; end
      else ack_wait--;
    end
    aif.mac_tx_ack = ack;
    if (dv && (ack || acked)) begin cap.push_back(aif.mac_tx_data); cur_len++; end
    if (ack) acked = 1;
    prev_dv = dv;
  endtask

  task automatic run_frames(input int n, input int budget);
    int i;
    i = 0;
    while (len_log.size() < n && i < budget) begin tick(); i++; end
    chk("frames_seen", len_log.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    aif.mac_tx_ack = 1'b0;
    clear_all();
    drive_src();
    repeat (2) @(posedge clk_125);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    aif.ch_valid = '0; aif.ch_data = '0; aif.ch_last = '0; aif.mac_tx_ack = 1'b0;
    bif.ch_valid = '0; bif.ch_data = '0; bif.ch_last = '0; bif.mac_tx_ack = 1'b0;
    clear_all();
    #1;
    // reset state, before any clock edge
    chk("rst_dvld", aif.mac_tx_dvld, 0);
    chk("rst_data", aif.mac_tx_data, 0);
    chk("rst_ur",   aif.mac_tx_underrun, 0);
    chk("rst_gnt",  a_gnt, 0);
    chk("rst_cnts", {a_fc[15:0], a_uc | a_tc}, 0);
    chk("rst_b",    {b_gnt, bif.mac_tx_dvld, b_fc[7:0]}, 0);
    do_reset();

    // single 10-byte frame on ch0, padded to 60
    push_frame(0, 10, 8'h01, 8'h01);
    run_frames(1, 300);
    repeat (3) tick();
    chk("t1_len", len_log[0], 60);
    chk("t1_dvld_run", run_log[0], 63);
    chk("t1_gnt", gnt_log[0], 4'b0001);
    for (int k = 0; k < 10; k++) chk($sformatf("t1_byte%0d", k + 1), cap[k], k + 1);
    nz = 0;
    for (int k = 10; k < 60; k++) if (cap[k] != 8'h00) nz++;
    chk("t1_pad_nonzero", nz, 0);
    chk("t1_fc", a_fc, 1);
    chk("t1_idle", {a_gnt, aif.mac_tx_dvld}, 0);

    // round-robin between ch0 and ch2, two 64-byte frames each
    do_reset();
    push_frame(0, 64, 8'h80, 8'h00); push_frame(2, 64, 8'hA0, 8'h00);
    push_frame(0, 64, 8'h81, 8'h00); push_frame(2, 64, 8'hA1, 8'h00);
    run_frames(4, 2000);
    repeat (3) tick();
    chk("t2_g0", gnt_log[0], 4'b0001);
    chk("t2_g1", gnt_log[1], 4'b0100);
    chk("t2_g2", gnt_log[2], 4'b0001);
    chk("t2_g3", gnt_log[3], 4'b0100);
    chk("t2_f0", cap[0], 8'h80);
    chk("t2_f1", cap[64], 8'hA0);
    chk("t2_f2", cap[128], 8'h81);
    chk("t2_f3", cap[192], 8'hA1);
    chk("t2_tail", cap[255], 8'd63);
    for (int f = 0; f < 4; f++) chk($sformatf("t2_len%0d", f), len_log[f], 64);
    // low time between frames: the GAP cycle plus the IDLE arbitration cycle
    for (int f = 0; f < 3; f++) chk($sformatf("t2_gap%0d", f), gap_log[f], 2);
    chk("t2_fc", a_fc, 4);

    // underrun on ch1 before byte 21, then a clean frame
    do_reset();
    push_frame(1, 30, 8'h01, 8'h01);
    push_frame(1, 10, 8'h41, 8'h41);
    stall_at[1] = 20; stall_rem[1] = 3;
    run_frames(2, 1000);
    repeat (3) tick();
    chk("t3_ur_pulses", ur_n, 1);
    chk("t3_ur_dvld", ur_bad, 0);
    chk("t3_ur_slot", ur_at, 20);
    chk("t3_len0", len_log[0], 20);
    chk("t3_len1", len_log[1], 60);
    chk("t3_byte20", cap[19], 8'd20);
    chk("t3_next_first", cap[20], 8'h41);
    chk("t3_cap_total", cap.size(), 80);
    chk("t3_drained", srcq[1].size(), 0);
    chk("t3_uc", a_uc, 1);
    chk("t3_fc", a_fc, 1);

    // ack never arrives: abort after 16 cycles and flush
    do_reset();
    ack_en = 0;
    push_frame(3, 5, 8'h31, 8'h31);
    run_frames(1, 100);
    repeat (10) tick();
    chk("t4_dvld_run", run_log[0], 16);
    chk("t4_no_bytes", cap.size(), 0);
    chk("t4_flushed", srcq[3].size(), 0);
    chk("t4_tc", a_tc, 1);
    chk("t4_fc", a_fc, 0);
    chk("t4_gnt", a_gnt, 0);

    // reset asserted while byte 30 is on the bus
    do_reset();
    push_frame(2, 40, 8'h01, 8'h01);
    hi = 0;
    while (cap.size() < 30 && hi < 300) begin tick(); hi++; end
    chk("t5_reach30", cap.size(), 30);
    chk("t5_byte30", aif.mac_tx_data, 8'd30);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_dvld", aif.mac_tx_dvld, 0);
    chk("t5_async_data", aif.mac_tx_data, 0);
    chk("t5_async_gnt",  a_gnt, 0);
    chk("t5_async_rdy",  aif.ch_ready, 0);
    clear_all();
    drive_src();
    repeat (2) @(posedge clk_125);
    #1 reset = 1'b0;
    push_frame(2, 10, 8'h51, 8'h51);
    push_frame(0, 10, 8'h61, 8'h61);
    run_frames(2, 400);
    repeat (3) tick();
    chk("t5_first_gnt", gnt_log[0], 4'b0001);
    chk("t5_second_gnt", gnt_log[1], 4'b0100);
    chk("t5_b0", cap[0], 8'h61);
    chk("t5_b1", cap[60], 8'h51);
    chk("t5_fc", a_fc, 2);

    // DUT B: timeout disabled, no padding, 1-byte frame
    @(posedge clk_125); #1;
    bif.ch_data = 16'h00A5; bif.ch_last = 2'b01; bif.ch_valid = 2'b01;
    #1 chk("b_rdy", bif.ch_ready, 2'b01);
    @(posedge clk_125); #1;
    bif.ch_valid = '0; bif.ch_last = '0;
    chk("b_dvld", bif.mac_tx_dvld, 1);
    chk("b_data", bif.mac_tx_data, 8'hA5);
    chk("b_gnt", b_gnt, 2'b01);
    hi = 0;
    repeat (200) begin
      @(posedge clk_125); #1;
      if (bif.mac_tx_dvld) hi++;
    end
    chk("b_no_timeout", hi, 200);
    chk("b_tc", b_tc, 0);
    bif.mac_tx_ack = 1'b1;
    @(posedge clk_125); #1;
    bif.mac_tx_ack = 1'b0;
    chk("b_dvld_end", bif.mac_tx_dvld, 0);
    chk("b_fc", b_fc, 1);
    @(posedge clk_125); #1;
    chk("b_gnt_end", b_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
